// File: rtl/kamikaze_pkg.sv
// rtl/kamikaze_pkg.sv - shared types and widths for the kamikaze memory arbiter
// Purpose: owner encoding used by the arbiter and its owner FIFO, plus datapath widths.
package kamikaze_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  // Which master issued a memory transaction; stored in the owner FIFO.
  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/kamikaze_owner_fifo.sv
// rtl/kamikaze_owner_fifo.sv - 1-bit-wide owner FIFO tracking outstanding memory transactions
// Purpose: remembers, in issue order, which master owns each outstanding transaction.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, din   : enqueue owner bit din
//   pop         : dequeue the head entry
//   head        : owner bit at the head (valid when !empty)
//   full, empty : occupancy flags
module kamikaze_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/kamikaze_mem_arbiter.sv
// rtl/kamikaze_mem_arbiter.sv - two-master (fetch, load/store) arbiter for the single memory port
// Purpose: forwards fetch and load/store requests to memory with LS priority and bounded
//          fetch starvation, and steers in-order responses back via an owner FIFO.
// Ports:
//   clk_i, rst_n_i           : clock, asynchronous active-low reset
//   if_*                     : fetch master (read-only) request/grant/response
//   ls_*                     : load/store master request/grant/response (rvalid acks writes)
//   mem_*                    : memory port, req/gnt handshake, one in-order rvalid per request
//   bus_err_o                : sticky, response seen with nothing outstanding
module kamikaze_mem_arbiter
  import kamikaze_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int LS_BURST_MAX    = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [BE_W-1:0] ls_be_i,
  input  logic [XLEN-1:0] ls_addr_i,
  input  logic [XLEN-1:0] ls_wdata_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic [XLEN-1:0] ls_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [BE_W-1:0] mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            bus_err_o
);

  localparam int SC_W = $clog2(LS_BURST_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(LS_BURST_MAX);

  owner_t          sel;
  owner_t          lock_owner_q;
  logic            lock_q;
  logic [SC_W-1:0] starve_cnt_q;
  logic            bus_err_q;
  logic            sel_req;
  logic            handshake;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_head;
  logic            fifo_pop;
  owner_t          head_owner;

  // A stalled request keeps its owner until memory accepts it, so the payload
  // seen by memory never changes mid-handshake; this also beats the starvation limit.
  always_comb begin
    sel = OWNER_IF;
    if (lock_q) begin
      sel = lock_owner_q;
    end else if (if_req_i && ls_req_i) begin
      sel = (starve_cnt_q == SC_MAX) ? OWNER_IF : OWNER_LS;
    end else if (ls_req_i) begin
      sel = OWNER_LS;
    end
  end

  assign sel_req = (sel == OWNER_LS) ? ls_req_i : if_req_i;

  // With the FIFO full a new request may only go out when a response frees a slot this cycle.
  assign mem_req_o = sel_req & ~(fifo_full & ~mem_rvalid_i);
  assign handshake = mem_req_o & mem_gnt_i;
  assign if_gnt_o  = handshake & (sel == OWNER_IF);
  assign ls_gnt_o  = handshake & (sel == OWNER_LS);

  // Payload is zeroed while no request is out so an idle port shows all zeros.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (sel == OWNER_LS) begin
        mem_we_o    = ls_we_i;
        mem_be_o    = ls_be_i;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = ls_wdata_i;
      end else begin
        mem_be_o    = '1;
        mem_addr_o  = if_addr_i;
      end
    end
  end

  assign fifo_pop   = mem_rvalid_i & ~fifo_empty;
  assign head_owner = owner_t'(fifo_head);

  assign if_rvalid_o = fifo_pop & (head_owner == OWNER_IF);
  assign ls_rvalid_o = fifo_pop & (head_owner == OWNER_LS);
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;
  assign bus_err_o   = bus_err_q;

  kamikaze_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (handshake),
    .pop   (fifo_pop),
    .din   (sel),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_IF;
      starve_cnt_q <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      lock_q <= mem_req_o & ~mem_gnt_i;
      if (mem_req_o && !mem_gnt_i) begin
        lock_owner_q <= sel;
      end

      if (!if_req_i || if_gnt_o) begin
        starve_cnt_q <= '0;
      end else if (ls_gnt_o && starve_cnt_q != SC_MAX) begin
        starve_cnt_q <= starve_cnt_q + SC_W'(1);
      end

      if (mem_rvalid_i && fifo_empty) begin
        bus_err_q <= 1'b1;
      end
    end
  end

endmodule
